// File: rtl/mem_edit_if.sv
// Keypad/memory/display bundle for the hex memory editor.
// master = controller side, slave = keypad, RAM and display side.
interface mem_edit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  localparam int NDIG_W = $clog2(DATA_W/4+1);

  logic [15:0]       d;
  logic              bs;
  logic              wr;
  logic              nxt;
  logic              pre;
  logic              busy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] edit_buf;
  logic [NDIG_W-1:0] ndig;
  logic              dirty;
  logic [3:0]        state;

  modport master (
    input  d, bs, wr, nxt, pre,
    input  busy, rd_data,
    output rd_en, wr_en, addr,
    output wr_data, edit_buf,
    output ndig, dirty, state
  );

  modport slave (
    output d, bs, wr, nxt, pre,
    output busy, rd_data,
    input  rd_en, wr_en, addr,
    input  wr_data, edit_buf,
    input  ndig, dirty, state
  );
endinterface

// File: rtl/mem_edit_ctrl.sv
// Hex-entry memory viewer/editor: browse, load, edit
// and commit words of a synchronous RAM.
module mem_edit_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int ADDR_MAX = 255,
  parameter int RD_LAT   = 1,
  parameter int AUTO_INC = 1
) (
  input  logic      clk,
  input  logic      rst,
  mem_edit_if.master bus
);
  localparam int NDIG   = DATA_W/4;
  localparam int NDIG_W = $clog2(NDIG+1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    WAIT  = 4'd2,
    READY = 4'd3,
    DIGIT = 4'd4,
    BACK  = 4'd5,
    WRITE = 4'd6,
    INC   = 4'd7,
    DEC   = 4'd8
  } state_t;

  state_t            st;
  logic [3:0]        k;
  logic [2:0]        cnt;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buf_q;
  logic [NDIG_W-1:0] ndig_q;
  logic              dirty_q;

  function automatic logic [3:0] lsb_idx(
    input logic [15:0] v
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      k       <= 4'd0;
      cnt     <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      buf_q   <= '0;
      ndig_q  <= '0;
      dirty_q <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      // another master owns the RAM: drop
      // everything, keep addr/buffer
      if (bus.busy) begin
        st <= IDLE;
      end else begin
        case (st)
          IDLE: begin
            st   <= LOAD;
            rd_q <= 1'b1;
          end
          LOAD: begin
            st  <= WAIT;
            cnt <= 3'd0;
          end
          WAIT: begin
            if (cnt == 3'(RD_LAT-1)) begin
              buf_q   <= bus.rd_data;
              ndig_q  <= '0;
              dirty_q <= 1'b0;
              st      <= READY;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          READY: begin
            if (|bus.d) begin
              k  <= lsb_idx(bus.d);
              st <= DIGIT;
            end else if (bus.bs) begin
              st <= BACK;
            end else if (bus.wr) begin
              st   <= WRITE;
              wr_q <= 1'b1;
            end else if (bus.nxt) begin
              st <= INC;
            end else if (bus.pre) begin
              st <= DEC;
            end
          end
          DIGIT: begin
            buf_q <= {buf_q[DATA_W-5:0], k};
            if (ndig_q != NDIG_W'(NDIG))
              ndig_q <= ndig_q + NDIG_W'(1);
            dirty_q <= 1'b1;
            st      <= READY;
          end
          BACK: begin
            buf_q <= buf_q >> 4;
            if (ndig_q != '0)
              ndig_q <= ndig_q - NDIG_W'(1);
            dirty_q <= 1'b1;
            st      <= READY;
          end
          WRITE: begin
            dirty_q <= 1'b0;
            ndig_q  <= '0;
            if (AUTO_INC != 0) begin
              st <= INC;
            end else begin
              st   <= LOAD;
              rd_q <= 1'b1;
            end
          end
          INC: begin
            if (addr_q == ADDR_W'(ADDR_MAX))
              addr_q <= '0;
            else
              addr_q <= addr_q + ADDR_W'(1);
            st   <= LOAD;
            rd_q <= 1'b1;
          end
          DEC: begin
            if (addr_q == '0)
              addr_q <= ADDR_W'(ADDR_MAX);
            else
              addr_q <= addr_q - ADDR_W'(1);
            st   <= LOAD;
            rd_q <= 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // strobes are squashed in the very cycle busy rises
  assign bus.rd_en    = rd_q & ~bus.busy;
  assign bus.wr_en    = wr_q & ~bus.busy;
  assign bus.addr     = addr_q;
  assign bus.wr_data  = buf_q;
  assign bus.edit_buf = buf_q;
  assign bus.ndig     = ndig_q;
  assign bus.dirty    = dirty_q;
  assign bus.state    = st;
endmodule

// File: tb/tb_mem_edit_ctrl.sv
// Directed bench for mem_edit_ctrl with a
// one-cycle-latency RAM model.
module tb_mem_edit_ctrl;
  logic clk;
  logic rst;
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  int n_tests;
  int n_fail;
  int rd_cnt;
  int wr_cnt;
  logic [7:0]  last_wa;
  logic [15:0] last_wd;

  typedef struct {
    logic [15:0] d;
    logic        bs;
    logic        wr;
    logic        nxt;
    logic        pre;
    logic [15:0] eb;
    logic [2:0]  en;
    logic        ed;
    logic [7:0]  ea;
    int          er;
    int          ew;
  } vec_t;

  vec_t vecs [27];

  mem_edit_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  mem_edit_ctrl #(
    .DATA_W(16), .ADDR_W(8), .ADDR_MAX(255),
    .RD_LAT(1), .AUTO_INC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rd_data = rd_q;

  always @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.addr] <= bus.wr_data;
      wr_cnt  = wr_cnt + 1;
      last_wa = bus.addr;
      last_wd = bus.wr_data;
    end
    if (bus.rd_en) begin
      rd_q <= mem[bus.addr];
      rd_cnt = rd_cnt + 1;
    end
  end

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (bus.state !== 4'd3 && n < 50) begin
      step();
      n++;
    end
    n_tests++;
    if (bus.state !== 4'd3) begin
      n_fail++;
      $display("FAIL %s: READY timeout, state %0d",
               nm, bus.state);
    end
  endtask

  task automatic clr_in();
    bus.d   = '0;
    bus.bs  = 1'b0;
    bus.wr  = 1'b0;
    bus.nxt = 1'b0;
    bus.pre = 1'b0;
  endtask

  initial begin
    int rc0, wc0;
    string nm;
    n_tests = 0;
    n_fail  = 0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    last_wa = '0;
    last_wd = '0;
    rd_q    = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]   = 16'h1234;
    mem[1]   = 16'h5678;
    mem[6]   = 16'h0606;
    mem[255] = 16'hA5A5;

    vecs[0]  = '{16'h0400,0,0,0,0,16'h234A,3'd1,1,8'd0,0,0};
    vecs[1]  = '{16'h0008,0,0,0,0,16'h34A3,3'd2,1,8'd0,0,0};
    vecs[2]  = '{16'h0000,1,0,0,0,16'h034A,3'd1,1,8'd0,0,0};
    vecs[3]  = '{16'h0005,1,0,0,0,16'h34A0,3'd2,1,8'd0,0,0};
    vecs[4]  = '{16'h0000,0,0,1,0,16'h5678,3'd0,0,8'd1,1,0};
    vecs[5]  = '{16'h0000,0,0,0,1,16'h1234,3'd0,0,8'd0,1,0};
    vecs[6]  = '{16'h0000,0,0,0,1,16'hA5A5,3'd0,0,8'd255,1,0};
    vecs[7]  = '{16'h0000,0,0,1,0,16'h1234,3'd0,0,8'd0,1,0};
    vecs[8]  = '{16'h0000,0,0,0,1,16'hA5A5,3'd0,0,8'd255,1,0};
    vecs[9]  = '{16'h0000,1,0,0,0,16'h0A5A,3'd0,1,8'd255,0,0};
    vecs[10] = '{16'h0000,0,0,1,0,16'h1234,3'd0,0,8'd0,1,0};
    vecs[11] = '{16'h0000,0,0,1,0,16'h5678,3'd0,0,8'd1,1,0};
    vecs[12] = '{16'h0000,0,0,1,0,16'h0000,3'd0,0,8'd2,1,0};
    vecs[13] = '{16'h0000,0,0,1,0,16'h0000,3'd0,0,8'd3,1,0};
    vecs[14] = '{16'h0000,0,0,1,0,16'h0000,3'd0,0,8'd4,1,0};
    vecs[15] = '{16'h0000,0,0,1,0,16'h0000,3'd0,0,8'd5,1,0};
    vecs[16] = '{16'h0800,0,0,0,0,16'h000B,3'd1,1,8'd5,0,0};
    vecs[17] = '{16'h4000,0,0,0,0,16'h00BE,3'd2,1,8'd5,0,0};
    vecs[18] = '{16'h4000,0,0,0,0,16'h0BEE,3'd3,1,8'd5,0,0};
    vecs[19] = '{16'h8000,0,0,0,0,16'hBEEF,3'd4,1,8'd5,0,0};
    vecs[20] = '{16'h0000,0,1,0,0,16'h0606,3'd0,0,8'd6,1,1};
    vecs[21] = '{16'h0000,0,0,0,1,16'hBEEF,3'd0,0,8'd5,1,0};
    vecs[22] = '{16'h0002,0,0,0,0,16'hEEF1,3'd1,1,8'd5,0,0};
    vecs[23] = '{16'h0004,0,0,0,0,16'hEF12,3'd2,1,8'd5,0,0};
    vecs[24] = '{16'h0008,0,0,0,0,16'hF123,3'd3,1,8'd5,0,0};
    vecs[25] = '{16'h0010,0,0,0,0,16'h1234,3'd4,1,8'd5,0,0};
    vecs[26] = '{16'h0020,0,0,0,0,16'h2345,3'd4,1,8'd5,0,0};

    rst      = 1'b1;
    bus.busy = 1'b0;
    clr_in();
    repeat (2) step();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_addr",  32'(bus.addr), 32'd0);
    chk("rst_buf",   32'(bus.edit_buf), 32'd0);
    chk("rst_ndig",  32'(bus.ndig), 32'd0);
    chk("rst_dirty", 32'(bus.dirty), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);

    rst = 1'b0;
    step();
    chk("c1_state", 32'(bus.state), 32'd1);
    chk("c1_rd_en", 32'(bus.rd_en), 32'd1);
    wait_ready("first_load");
    chk("ld_buf",   32'(bus.edit_buf), 32'h1234);
    chk("ld_dirty", 32'(bus.dirty), 32'd0);
    chk("ld_ndig",  32'(bus.ndig), 32'd0);
    chk("ld_rdcnt", 32'(rd_cnt), 32'd1);

    for (int i = 0; i < 27; i++) begin
      nm = $sformatf("vec%0d", i);
      wait_ready({nm, "_pre"});
      rc0 = rd_cnt;
      wc0 = wr_cnt;
      bus.d   = vecs[i].d;
      bus.bs  = vecs[i].bs;
      bus.wr  = vecs[i].wr;
      bus.nxt = vecs[i].nxt;
      bus.pre = vecs[i].pre;
      step();
      clr_in();
      wait_ready(nm);
      chk({nm, "_buf"}, 32'(bus.edit_buf),
          32'(vecs[i].eb));
      chk({nm, "_ndig"}, 32'(bus.ndig),
          32'(vecs[i].en));
      chk({nm, "_dirty"}, 32'(bus.dirty),
          32'(vecs[i].ed));
      chk({nm, "_addr"}, 32'(bus.addr),
          32'(vecs[i].ea));
      chk({nm, "_rd"}, 32'(rd_cnt - rc0),
          32'(vecs[i].er));
      chk({nm, "_wr"}, 32'(wr_cnt - wc0),
          32'(vecs[i].ew));
    end
    chk("wr_addr", 32'(last_wa), 32'd5);
    chk("wr_data", 32'(last_wd), 32'hBEEF);

    // commit aborted by busy in WRITE
    wc0 = wr_cnt;
    rc0 = rd_cnt;
    bus.wr = 1'b1;
    step();
    clr_in();
    chk("bw_state", 32'(bus.state), 32'd6);
    bus.busy = 1'b1;
    #1;
    chk("bw_wr_en", 32'(bus.wr_en), 32'd0);
    repeat (3) step();
    chk("bw_idle",  32'(bus.state), 32'd0);
    chk("bw_addr",  32'(bus.addr), 32'd5);
    chk("bw_buf",   32'(bus.edit_buf), 32'h2345);
    bus.busy = 1'b0;
    wait_ready("bw_reload");
    chk("bw_wrcnt", 32'(wr_cnt - wc0), 32'd0);
    chk("bw_rdcnt", 32'(rd_cnt - rc0), 32'd1);
    chk("bw_raddr", 32'(bus.addr), 32'd5);
    chk("bw_rbuf",  32'(bus.edit_buf), 32'hBEEF);
    chk("bw_rdirty", 32'(bus.dirty), 32'd0);

    // reset while a read strobe is in flight
    bus.nxt = 1'b1;
    step();
    clr_in();
    step();
    chk("mr_state", 32'(bus.state), 32'd1);
    chk("mr_rd_en", 32'(bus.rd_en), 32'd1);
    chk("mr_addr",  32'(bus.addr), 32'd6);
    rst = 1'b1;
    #1;
    chk("mr_rd_clr", 32'(bus.rd_en), 32'd0);
    chk("mr_st_clr", 32'(bus.state), 32'd0);
    chk("mr_ad_clr", 32'(bus.addr), 32'd0);
    chk("mr_bf_clr", 32'(bus.edit_buf), 32'd0);
    step();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
